pipe_hazard_ctrl: RTL and testbench

- Parametrised successor to the 5-stage RV32 hazard-detection and forwarding logic.
- One block generates every pipeline enable, flush and bubble, plus every forward select.
- Adds two things the current logic lacks: a multi-cycle EX unit (MUL/DIV) with a latency counter FSM, and forwarding into the ID-stage branch comparator.
- Sits beside the datapath. Drives the PC, IF/ID, ID/EX and EX/MEM enables, and the EX-stage and ID-stage operand muxes.

---
 rtl/pipe_hazard_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard detection and forwarding control for a 5-stage RV32
// pipeline. It drives all pipeline enables, flushes and bubbles, the EX-stage
// and ID-stage (branch comparator) forward selects, and sequences a multi-cycle
// EX unit through IDLE/BUSY/DONE.
// Optional feature: define HAZARD_PERF_EN to add saturating stall/flush counters.
module pipe_hazard_ctrl #(
    parameter int REG_IDX = 5,
    parameter int MC_LAT  = 4
`ifdef HAZARD_PERF_EN
    ,
    parameter int PERF_W  = 16
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [REG_IDX-1:0] id_rs1,
    input  logic [REG_IDX-1:0] id_rs2,
    input  logic               id_use_rs1,
    input  logic               id_use_rs2,
    input  logic               id_is_branch,
    input  logic               id_br_taken,
    input  logic [REG_IDX-1:0] ex_rs1,
    input  logic [REG_IDX-1:0] ex_rs2,
    input  logic [REG_IDX-1:0] ex_rd,
    input  logic               ex_regwrite,
    input  logic               ex_memread,
    input  logic               ex_mc_op,
    input  logic [REG_IDX-1:0] mem_rd,
    input  logic               mem_regwrite,
    input  logic               mem_memread,
    input  logic [REG_IDX-1:0] wb_rd,
    input  logic               wb_regwrite,
    output logic               pc_we,
    output logic               if_id_we,
    output logic               if_id_flush,
    output logic               id_ex_we,
    output logic               id_ex_bubble,
    output logic               ex_mem_bubble,
    output logic               mc_busy,
    output logic               mc_done,
    output logic [1:0]         fwd_a,
    output logic [1:0]         fwd_b,
    output logic [1:0]         fwd_id_a,
    output logic [1:0]         fwd_id_b
`ifdef HAZARD_PERF_EN
    ,
    output logic [PERF_W-1:0]  perf_load_stall,
    output logic [PERF_W-1:0]  perf_br_stall,
    output logic [PERF_W-1:0]  perf_mc_stall,
    output logic [PERF_W-1:0]  perf_flush
`endif
);

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} mc_state_t;

    // Counter holds the remaining registered BUSY cycles (at most MC_LAT-2).
    localparam int              CNT_W    = $clog2(MC_LAT);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MC_LAT - 2);

    mc_state_t        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             busy_int;
    logic             load_use, br_ex, br_load, dstall;
    logic [1:0]       sel_ex_a, sel_ex_b, sel_id_a, sel_id_b;

    // A producer matches a source only if it writes, and never for x0.
    function automatic logic hit(input logic [REG_IDX-1:0] src,
                                 input logic [REG_IDX-1:0] rd,
                                 input logic               we);
        return we && (rd != '0) && (rd == src);
    endfunction

    // Does a producer hit any source the ID instruction actually reads?
    function automatic logic id_hit(input logic [REG_IDX-1:0] rd,
                                    input logic               we);
        return (id_use_rs1 && hit(id_rs1, rd, we)) ||
               (id_use_rs2 && hit(id_rs2, rd, we));
    endfunction

    // Forward selects and stall detection; EX/MEM wins over MEM/WB.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        sel_ex_a = 2'b00;
        sel_ex_b = 2'b00;
        sel_id_a = 2'b00;
        sel_id_b = 2'b00;
        if (hit(ex_rs1, mem_rd, mem_regwrite))      sel_ex_a = 2'b01;
        else if (hit(ex_rs1, wb_rd, wb_regwrite))   sel_ex_a = 2'b10;
        if (hit(ex_rs2, mem_rd, mem_regwrite))      sel_ex_b = 2'b01;
        else if (hit(ex_rs2, wb_rd, wb_regwrite))   sel_ex_b = 2'b10;
        // A load in MEM has no data yet, so it cannot feed the comparator.
        if (id_is_branch) begin
            if (!mem_memread && hit(id_rs1, mem_rd, mem_regwrite)) sel_id_a = 2'b01;
            else if (hit(id_rs1, wb_rd, wb_regwrite))              sel_id_a = 2'b10;
            if (!mem_memread && hit(id_rs2, mem_rd, mem_regwrite)) sel_id_b = 2'b01;
            else if (hit(id_rs2, wb_rd, wb_regwrite))              sel_id_b = 2'b10;
        end
        load_use = ex_memread && id_hit(ex_rd, ex_regwrite);
        br_ex    = id_is_branch && id_hit(ex_rd, ex_regwrite);
        br_load  = id_is_branch && mem_memread && id_hit(mem_rd, mem_regwrite);
        dstall   = load_use || br_ex || br_load;
    end

    // Multi-cycle unit state register; reset aborts any op in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Multi-cycle next state; DONE always returns to IDLE so a held ex_mc_op
    // cannot re-trigger on the op that just finished.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: begin
                if (ex_mc_op) begin
                    state_nxt = (MC_LAT == 2) ? ST_DONE : ST_BUSY;
                    cnt_nxt   = CNT_LOAD;
                end
            end
            ST_BUSY: begin
                if (cnt <= CNT_W'(1)) begin
                    state_nxt = ST_DONE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // The op's first cycle is still IDLE, so occupancy there is combinational.
    assign busy_int = (state == ST_BUSY) || ((state == ST_IDLE) && ex_mc_op);

    // Pipeline controls: reset > mc_busy > data stall > taken branch.
    always_comb begin
        pc_we         = 1'b1;
        if_id_we      = 1'b1;
        id_ex_we      = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_bubble  = 1'b0;
        ex_mem_bubble = 1'b0;
        mc_busy       = busy_int;
        mc_done       = (state == ST_DONE);
        fwd_a         = sel_ex_a;
        fwd_b         = sel_ex_b;
        fwd_id_a      = sel_id_a;
        fwd_id_b      = sel_id_b;
        if (!rst) begin
            pc_we         = 1'b0;
            if_id_we      = 1'b0;
            id_ex_we      = 1'b0;
            if_id_flush   = 1'b1;
            id_ex_bubble  = 1'b1;
            ex_mem_bubble = 1'b1;
            mc_busy       = 1'b0;
            mc_done       = 1'b0;
            fwd_a         = 2'b00;
            fwd_b         = 2'b00;
            fwd_id_a      = 2'b00;
            fwd_id_b      = 2'b00;
        end else if (busy_int) begin
            pc_we         = 1'b0;
            if_id_we      = 1'b0;
            id_ex_we      = 1'b0;
            ex_mem_bubble = 1'b1;
        end else if (dstall) begin
            pc_we        = 1'b0;
            if_id_we     = 1'b0;
            id_ex_bubble = 1'b1;
        end else if (id_br_taken) begin
            if_id_flush = 1'b1;
        end
    end

`ifdef HAZARD_PERF_EN
    // Saturating event counters; they stick at all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_load_stall <= '0;
            perf_br_stall   <= '0;
            perf_mc_stall   <= '0;
            perf_flush      <= '0;
        end else begin
            if (load_use && !busy_int && (perf_load_stall != '1))
                perf_load_stall <= perf_load_stall + 1'b1;
            if ((br_ex || br_load) && !load_use && !busy_int && (perf_br_stall != '1))
                perf_br_stall <= perf_br_stall + 1'b1;
            if (busy_int && (perf_mc_stall != '1))
                perf_mc_stall <= perf_mc_stall + 1'b1;
            if (if_id_flush && (perf_flush != '1))
                perf_flush <= perf_flush + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: table-driven combinational vectors, hand
// sequences for multi-cycle corners, and randomized stimulus against a model.
module tb_pipe_hazard_ctrl;

    localparam int REG_IDX = 5;
    localparam int MC_LAT  = 4;

    logic clk = 1'b0;
    logic rst;
    logic [REG_IDX-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic id_use_rs1, id_use_rs2, id_is_branch, id_br_taken;
    logic ex_regwrite, ex_memread, ex_mc_op, mem_regwrite, mem_memread, wb_regwrite;
    logic pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_bubble, ex_mem_bubble;
    logic mc_busy, mc_done;
    logic [1:0] fwd_a, fwd_b, fwd_id_a, fwd_id_b;
`ifdef HAZARD_PERF_EN
    logic [3:0] perf_load_stall, perf_br_stall, perf_mc_stall, perf_flush;
`endif

    always #5 clk = ~clk;

`ifdef HAZARD_PERF_EN
    pipe_hazard_ctrl #(.REG_IDX(REG_IDX), .MC_LAT(MC_LAT), .PERF_W(4)) dut (
`else
    pipe_hazard_ctrl #(.REG_IDX(REG_IDX), .MC_LAT(MC_LAT)) dut (
`endif
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_is_branch(id_is_branch), .id_br_taken(id_br_taken),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_mc_op(ex_mc_op),
        .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .mem_memread(mem_memread),
        .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
        .pc_we(pc_we), .if_id_we(if_id_we), .if_id_flush(if_id_flush),
        .id_ex_we(id_ex_we), .id_ex_bubble(id_ex_bubble), .ex_mem_bubble(ex_mem_bubble),
        .mc_busy(mc_busy), .mc_done(mc_done),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_id_a(fwd_id_a), .fwd_id_b(fwd_id_b)
`ifdef HAZARD_PERF_EN
        , .perf_load_stall(perf_load_stall), .perf_br_stall(perf_br_stall),
        .perf_mc_stall(perf_mc_stall), .perf_flush(perf_flush)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 0; id_use_rs2 = 0;
        id_is_branch = 0; id_br_taken = 0;
        ex_rs1 = '0; ex_rs2 = '0; ex_rd = '0; ex_regwrite = 0; ex_memread = 0; ex_mc_op = 0;
        mem_rd = '0; mem_regwrite = 0; mem_memread = 0; wb_rd = '0; wb_regwrite = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    typedef struct {
        string name;
        int id_rs1, id_rs2, use1, use2, is_br, taken;
        int ex_rs1, ex_rs2, ex_rd, ex_rw, ex_mr;
        int mem_rd, mem_rw, mem_mr, wb_rd, wb_rw;
        int e_fa, e_fb, e_fia, e_fib, e_pc, e_flush, e_bub;
    } vec_t;

    vec_t vecs[12];

    // Reference model: selects and stalls derived from the forwarding/stall rules.
    function automatic int ex_sel(input logic [REG_IDX-1:0] rs);
        if (rs != 0 && mem_regwrite && mem_rd == rs) return 1;
        if (rs != 0 && wb_regwrite && wb_rd == rs) return 2;
        return 0;
    endfunction

    function automatic int id_sel(input logic [REG_IDX-1:0] rs);
        if (!id_is_branch) return 0;
        if (rs != 0 && mem_regwrite && !mem_memread && mem_rd == rs) return 1;
        if (rs != 0 && wb_regwrite && wb_rd == rs) return 2;
        return 0;
    endfunction

    function automatic bit reads(input logic [REG_IDX-1:0] rd, input logic rw);
        return rd != 0 && rw && ((id_use_rs1 && id_rs1 == rd) || (id_use_rs2 && id_rs2 == rd));
    endfunction

    int  phase;
    bit  m_busy, m_done, m_stall;

    initial begin
        rst = 1'b0;
        clear_inputs();
        // Reset state, checked before any clock edge.
        #1;
        check("rst_pc_we", pc_we, 0);
        check("rst_if_id_flush", if_id_flush, 1);
        check("rst_bubbles", {id_ex_bubble, ex_mem_bubble, id_ex_we, if_id_we}, 4'b1100);
        check("rst_mc", {mc_busy, mc_done}, 0);
        @(negedge clk);
        rst = 1'b1;

        // ------------- table-driven combinational vectors -------------
        //           name        rs1 rs2 u1 u2 br tk exr1 exr2 exrd erw emr mrd mrw mmr wrd wrw  fa fb fia fib pc fl bub
        vecs[0]  = '{"fwd_mem",    0, 0, 0, 0, 0, 0,  7,  0,  0, 0, 0,  7, 1, 0,  7, 1,  1, 0, 0, 0, 1, 0, 0};
        vecs[1]  = '{"fwd_wb",     0, 0, 0, 0, 0, 0,  7,  0,  0, 0, 0,  0, 1, 0,  7, 1,  2, 0, 0, 0, 1, 0, 0};
        vecs[2]  = '{"fwd_x0",     0, 0, 0, 0, 0, 0,  0,  0,  0, 0, 0,  0, 1, 0,  0, 1,  0, 0, 0, 0, 1, 0, 0};
        vecs[3]  = '{"fwd_b_norw", 0, 0, 0, 0, 0, 0,  0,  3,  0, 0, 0,  3, 0, 0,  3, 1,  0, 2, 0, 0, 1, 0, 0};
        vecs[4]  = '{"load_use",   5, 0, 1, 0, 0, 0,  0,  0,  5, 1, 1,  0, 0, 0,  0, 0,  0, 0, 0, 0, 0, 0, 1};
        vecs[5]  = '{"lu_unused",  5, 0, 0, 0, 0, 0,  0,  0,  5, 1, 1,  0, 0, 0,  0, 0,  0, 0, 0, 0, 1, 0, 0};
        vecs[6]  = '{"br_ex",      0, 4, 0, 1, 1, 1,  0,  0,  4, 1, 0,  0, 0, 0,  0, 0,  0, 0, 0, 0, 0, 0, 1};
        vecs[7]  = '{"br_load",    3, 0, 1, 0, 1, 1,  0,  0,  0, 0, 0,  3, 1, 1,  0, 0,  0, 0, 0, 0, 0, 0, 1};
        vecs[8]  = '{"br_fwd_id",  3, 6, 1, 1, 1, 1,  0,  0,  0, 0, 0,  3, 1, 0,  6, 1,  0, 0, 1, 2, 1, 1, 0};
        vecs[9]  = '{"jump_nobr",  3, 6, 1, 1, 0, 1,  0,  0,  0, 0, 0,  3, 1, 0,  6, 1,  0, 0, 0, 0, 1, 1, 0};
        vecs[10] = '{"id_wb_sel",  3, 0, 1, 0, 1, 0,  0,  0,  0, 0, 0,  3, 0, 0,  3, 1,  0, 0, 2, 0, 1, 0, 0};
        vecs[11] = '{"br_ex_x0",   0, 0, 1, 1, 1, 0,  0,  0,  0, 1, 0,  0, 0, 0,  0, 0,  0, 0, 0, 0, 1, 0, 0};

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            id_rs1 = 5'(vecs[i].id_rs1); id_rs2 = 5'(vecs[i].id_rs2);
            id_use_rs1 = 1'(vecs[i].use1); id_use_rs2 = 1'(vecs[i].use2);
            id_is_branch = 1'(vecs[i].is_br); id_br_taken = 1'(vecs[i].taken);
            ex_rs1 = 5'(vecs[i].ex_rs1); ex_rs2 = 5'(vecs[i].ex_rs2); ex_rd = 5'(vecs[i].ex_rd);
            ex_regwrite = 1'(vecs[i].ex_rw); ex_memread = 1'(vecs[i].ex_mr); ex_mc_op = 0;
            mem_rd = 5'(vecs[i].mem_rd); mem_regwrite = 1'(vecs[i].mem_rw);
            mem_memread = 1'(vecs[i].mem_mr);
            wb_rd = 5'(vecs[i].wb_rd); wb_regwrite = 1'(vecs[i].wb_rw);
            #1;
            check({vecs[i].name, ".fwd"}, {fwd_a, fwd_b, fwd_id_a, fwd_id_b},
                  {2'(vecs[i].e_fa), 2'(vecs[i].e_fb), 2'(vecs[i].e_fia), 2'(vecs[i].e_fib)});
            check({vecs[i].name, ".ctl"}, {pc_we, if_id_we, if_id_flush, id_ex_bubble, id_ex_we},
                  {1'(vecs[i].e_pc), 1'(vecs[i].e_pc), 1'(vecs[i].e_flush), 1'(vecs[i].e_bub), 1'b1});
        end

        // ------------- load-use: one stall, then MEM/WB forward -------------
        @(negedge clk); clear_inputs();
        ex_rd = 5; ex_regwrite = 1; ex_memread = 1; id_rs1 = 5; id_rs2 = 1;
        id_use_rs1 = 1; id_use_rs2 = 1;
        #1 check("lu_c1_stall", {pc_we, if_id_we, id_ex_bubble}, 3'b001);
        @(negedge clk);
        ex_rd = 0; ex_regwrite = 0; ex_memread = 0;
        mem_rd = 5; mem_regwrite = 1; mem_memread = 1;
        #1 check("lu_c2_run", {pc_we, if_id_we, id_ex_bubble}, 3'b110);
        @(negedge clk); clear_inputs();
        ex_rs1 = 5; ex_rs2 = 1; ex_rd = 6; ex_regwrite = 1; wb_rd = 5; wb_regwrite = 1;
        #1 check("lu_c3_fwd_a", fwd_a, 2'b10);

        // ------------- branch on a load: two stalls, then flush -------------
        @(negedge clk); clear_inputs();
        id_rs1 = 3; id_use_rs1 = 1; id_is_branch = 1; id_br_taken = 1;
        ex_rd = 3; ex_regwrite = 1; ex_memread = 1;
        #1 check("brl_c1", {pc_we, id_ex_bubble, if_id_flush}, 3'b010);
        @(negedge clk);
        ex_rd = 0; ex_regwrite = 0; ex_memread = 0;
        mem_rd = 3; mem_regwrite = 1; mem_memread = 1;
        #1 check("brl_c2", {pc_we, id_ex_bubble, if_id_flush}, 3'b010);
        @(negedge clk);
        mem_rd = 0; mem_regwrite = 0; mem_memread = 0; wb_rd = 3; wb_regwrite = 1;
        #1 check("brl_c3", {pc_we, id_ex_bubble, if_id_flush, fwd_id_a}, 5'b10110);

        // ------------- multi-cycle op, back-to-back, reset mid-BUSY -------------
        @(negedge clk); clear_inputs(); ex_mc_op = 1;
        for (int c = 1; c <= 3; c++) begin
            #1 check($sformatf("mc_c%0d_busy", c), {mc_busy, mc_done, pc_we, ex_mem_bubble, id_ex_we}, 5'b10010);
            @(negedge clk);
        end
        #1 check("mc_c4_done", {mc_busy, mc_done, pc_we, ex_mem_bubble, id_ex_we}, 5'b01101);
        @(negedge clk);
        #1 check("mc_c5_restart", {mc_busy, mc_done}, 2'b10);
        @(negedge clk);
        ex_rs1 = 7; mem_rd = 7; mem_regwrite = 1;
        #1 check("mc_busy_fwd", {mc_busy, fwd_a}, 3'b101);
        rst = 1'b0;
        #1 check("mc_rst_async", {mc_busy, mc_done, pc_we, if_id_we, id_ex_we, if_id_flush,
                                  id_ex_bubble, ex_mem_bubble, fwd_a, fwd_b, fwd_id_a, fwd_id_b},
                 20'b00000111_00000000);
        ex_mc_op = 0;
        @(negedge clk); rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1 check("mc_no_done", {mc_busy, mc_done}, 2'b00);
            @(negedge clk);
        end

        // ------------- randomized stimulus vs reference model -------------
        do_reset();
        phase = 0;
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
            ex_rs1 = 5'($urandom_range(0, 3)); ex_rs2 = 5'($urandom_range(0, 3));
            ex_rd = 5'($urandom_range(0, 3)); mem_rd = 5'($urandom_range(0, 3));
            wb_rd = 5'($urandom_range(0, 3));
            {id_use_rs1, id_use_rs2, id_is_branch, id_br_taken} = 4'($urandom);
            {ex_regwrite, ex_memread, mem_regwrite, mem_memread, wb_regwrite} = 5'($urandom);
            ex_mc_op = ($urandom_range(0, 7) == 0);
            #1;
            m_busy  = (phase == 0) ? ex_mc_op : (phase + 1 < MC_LAT);
            m_done  = (phase != 0) && (phase + 1 == MC_LAT);
            m_stall = (ex_memread && reads(ex_rd, ex_regwrite)) ||
                      (id_is_branch && reads(ex_rd, ex_regwrite)) ||
                      (id_is_branch && mem_memread && reads(mem_rd, mem_regwrite));
            check("rnd_fwd", {fwd_a, fwd_b, fwd_id_a, fwd_id_b},
                  {2'(ex_sel(ex_rs1)), 2'(ex_sel(ex_rs2)), 2'(id_sel(id_rs1)), 2'(id_sel(id_rs2))});
            check("rnd_ctl", {mc_busy, mc_done, pc_we, if_id_we, id_ex_we, id_ex_bubble, ex_mem_bubble, if_id_flush},
                  {m_busy, m_done, !m_busy && !m_stall, !m_busy && !m_stall, !m_busy,
                   !m_busy && m_stall, m_busy, id_br_taken && !m_busy && !m_stall});
            @(posedge clk);
            if (phase == 0) phase = ex_mc_op ? 1 : 0;
            else            phase = (phase + 1 == MC_LAT) ? 0 : phase + 1;
        end

`ifdef HAZARD_PERF_EN
        // ------------- saturating perf counter -------------
        do_reset();
        clear_inputs();
        ex_rd = 5; ex_regwrite = 1; ex_memread = 1; id_rs1 = 5; id_use_rs1 = 1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        #1 check("perf_load_sat", perf_load_stall, 4'd15);
        check("perf_others", {perf_br_stall, perf_mc_stall, perf_flush}, 12'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
